router_op_lut_event_pacer: RTL and testbench
============================================

// Module: router_op_lut_event_pacer
// PURPOSE
//  Sits between op_lut_process_sm and the op-LUT counter register block. Takes the raw per-packet event
//  pulses (arp/lpm miss, forwarded, bad ttl, ...), which may arrive back-to-back, and re-times them so
//  each channel emits at most one update pulse per MIN_UPDATE_INTERVAL clocks. Bursts are held in
//  small per-channel pending counters, so no event is lost unless a counter saturates.
// PARAMETERS
//  NUM_EVENTS           10  number of independent event channels (bit i = counter index i)
//  MIN_UPDATE_INTERVAL  8   min clocks between successive update pulses on one channel; legal >= 1
//  ACC_WIDTH            4   pending-count width per channel; saturates at 2**ACC_WIDTH-1
// PORTS
//  clk           in   1           system clock
//  reset         in   1           asynchronous, active-low reset (asserted when 0)
//  events_in     in   NUM_EVENTS  1-cycle event pulses from op_lut_process_sm; any combination per cycle
//  updates_out   out  NUM_EVENTS  registered 1-cycle update pulses to the counter register block
//  overflow      out  NUM_EVENTS  sticky: channel dropped >= 1 event at saturation
//  clear_ovfl    in   NUM_EVENTS  1-cycle clear of the matching overflow bits
//  busy          out  1           registered; 1 while any channel has pending != 0
// BEHAVIOUR
//  Reset (reset==0, async): pending, timer, updates_out, overflow, busy all 0. Mid-operation reset
//   discards all pending events; the first event after release is paced as if from idle.
//  Per channel i, per cycle, with ev = events_in[i]:
//   - can_emit = (timer == 0); emit = can_emit && (pending != 0 || ev).
//   - updates_out[i] <= emit  (decision in cycle t -> pulse high in cycle t+1, exactly 1 cycle).
//   - On emit: timer <= MIN_UPDATE_INTERVAL-1; else if timer != 0: timer <= timer-1.
//     Next emit on the channel is therefore >= MIN_UPDATE_INTERVAL cycles after the previous one.
//     MIN_UPDATE_INTERVAL==1: timer stays 0; every cycle may emit.
//   - pending_next = pending + ev - emit (ev && emit: pending unchanged; idle channel + single event:
//     emitted directly, pending stays 0).
//   - Saturation: pending == MAX && ev && !emit -> pending holds MAX, event dropped,
//     overflow[i] <= 1.
//  overflow: set has priority over clear_ovfl in the same cycle (no event loss goes unflagged).
//  busy <= |(pending_next of all channels).
//  Channels are fully independent; simultaneous events on different channels pace separately.
//  Width rules: timer width = max(1, $clog2(MIN_UPDATE_INTERVAL)); pending arithmetic in ACC_WIDTH
//   unsigned, no wrap-around (saturating up; decrement only when pending != 0 or ev).
//  Fixed latency: event -> update pulse >= 1 cycle; worst case for an event accepted when pending == p
//   and the channel just emitted: 1 + (p+1)*MIN_UPDATE_INTERVAL cycles.
//  No handshake with downstream: downstream samples updates_out every cycle.
// STRUCTURE
//  Shared defines header: counter-index defines (ROUTER_OP_LUT_ARP_NUM_MISSES, ..._LPM_NUM_MISSES,
//   ..._NUM_PKTS_FORWARDED, etc.) so the event-bit order matches the counter block's update bits.
//  Sub-module router_op_lut_event_pacer_chan: one channel (pending, timer, emit, overflow), built
//   NUM_EVENTS times in a generate loop. The top level holds the busy OR-reduce and the port concat.
// TESTING (NUM_EVENTS=10, MIN_UPDATE_INTERVAL=8, ACC_WIDTH=4 unless stated)
//  1 Single pulse events_in[3] at cycle 0, idle channel -> updates_out[3] high only in cycle 1;
//    busy stays 0; other bits stay 0.
//  2 events_in[2] on cycles 0,1,2 -> updates_out[2] pulses in cycles 1, 9, 17 only;
//    busy 1 from cycle 2 through cycle 16.
//  3 events_in[5] held high cycles 0..19 (20 events) -> pulses at 1,9,17,25,...; pending peaks at 15;
//    overflow[5]=1 after cycle 18; 18 pulses in total, 2 dropped.
//  4 All 10 bits pulsed together at cycle 0 -> all 10 updates_out bits high in cycle 1; no overflow.
//  5 clear_ovfl[5] asserted on an idle channel -> overflow[5]=0 next cycle. Repeat scenario 3 with
//    clear_ovfl[5] asserted in the same cycle as a drop -> overflow[5] stays 1.
//  6 Reset low at cycle 4 of scenario 2 -> all outputs 0 immediately; after release, a new
//    events_in[2] at cycle t -> pulse at t+1, with no leftover pulses.

Source files
------------

// File: rtl/router_op_lut_event_pacer_pkg.sv
// router_op_lut_event_pacer_pkg: shared counter indices, default parameters and width helper
//   Counter indices fix the event-bit order so that events_in[i] / updates_out[i]
//   line up with update bit i of the op-LUT counter register block.
package router_op_lut_event_pacer_pkg;

    typedef enum int {
        ROUTER_OP_LUT_ARP_NUM_MISSES        = 0,
        ROUTER_OP_LUT_LPM_NUM_MISSES        = 1,
        ROUTER_OP_LUT_NUM_CPU_PKTS_SENT     = 2,
        ROUTER_OP_LUT_NUM_BAD_OPTS_VER      = 3,
        ROUTER_OP_LUT_NUM_BAD_CHKSUMS       = 4,
        ROUTER_OP_LUT_NUM_BAD_TTLS          = 5,
        ROUTER_OP_LUT_NUM_NON_IP_RCVD       = 6,
        ROUTER_OP_LUT_NUM_PKTS_FORWARDED    = 7,
        ROUTER_OP_LUT_NUM_WRONG_DEST        = 8,
        ROUTER_OP_LUT_NUM_FILTERED_PKTS     = 9
    } counter_idx_e;

    localparam int NUM_COUNTERS            = 10;
    localparam int DEF_MIN_UPDATE_INTERVAL = 8;
    localparam int DEF_ACC_WIDTH           = 4;

    // Timer must hold MIN_UPDATE_INTERVAL-1; never narrower than one bit.
    function automatic int timer_width(input int min_interval);
        return (min_interval <= 2) ? 1 : $clog2(min_interval);
    endfunction

endpackage

// File: rtl/router_op_lut_event_pacer_if.sv
// router_op_lut_event_pacer_if: event/update bundle between the process SM side and the pacer
//   events_in    raw 1-cycle event pulses, one bit per counter
//   clear_ovfl   1-cycle clear of matching overflow bits
//   updates_out  paced 1-cycle update pulses to the counter register block
//   overflow     sticky per-channel drop flag
//   busy         any channel still holds pending events
interface router_op_lut_event_pacer_if #(
    parameter int NUM_EVENTS = 10
);
    logic [NUM_EVENTS-1:0] events_in;
    logic [NUM_EVENTS-1:0] clear_ovfl;
    logic [NUM_EVENTS-1:0] updates_out;
    logic [NUM_EVENTS-1:0] overflow;
    logic                  busy;

    modport master (
        output events_in, clear_ovfl,
        input  updates_out, overflow, busy
    );

    modport slave (
        input  events_in, clear_ovfl,
        output updates_out, overflow, busy
    );
endinterface

// File: rtl/router_op_lut_event_pacer_chan.sv
// router_op_lut_event_pacer_chan: one pacing channel (pending count, interval timer, overflow)
//   clk      system clock
//   reset    asynchronous active-low reset
//   ev       1-cycle event pulse
//   clear    1-cycle clear of the sticky overflow flag
//   update   registered 1-cycle update pulse, at most one per MIN_UPDATE_INTERVAL clocks
//   ovfl     sticky: an event was dropped because pending was saturated
//   pend_nz  combinational: pending count after this cycle is non-zero
module router_op_lut_event_pacer_chan
    import router_op_lut_event_pacer_pkg::*;
#(
    parameter int MIN_UPDATE_INTERVAL = DEF_MIN_UPDATE_INTERVAL,
    parameter int ACC_WIDTH           = DEF_ACC_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic ev,
    input  logic clear,
    output logic update,
    output logic ovfl,
    output logic pend_nz
);
    localparam int                   TW     = timer_width(MIN_UPDATE_INTERVAL);
    localparam logic [ACC_WIDTH-1:0] MAX    = '1;
    localparam logic [TW-1:0]        RELOAD = TW'(MIN_UPDATE_INTERVAL - 1);

    logic [ACC_WIDTH-1:0] pending;
    logic [ACC_WIDTH-1:0] pending_next;
    logic [TW-1:0]        timer;
    logic                 emit;
    logic                 drop;

    // An event arriving while the channel may emit goes straight out, so
    // ev && emit leaves pending unchanged; a saturated channel drops the event.
    always_comb begin
        emit         = (timer == '0) && (pending != '0 || ev);
        drop         = ev && !emit && (pending == MAX);
        pending_next = (ev && !emit && !drop) ? pending + ACC_WIDTH'(1) :
                       (emit && !ev)          ? pending - ACC_WIDTH'(1) : pending;
    end

    assign pend_nz = (pending_next != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            timer   <= '0;
            update  <= 1'b0;
            ovfl    <= 1'b0;
        end else begin
            pending <= pending_next;
            update  <= emit;
            timer   <= emit ? RELOAD : (timer != '0) ? timer - TW'(1) : timer;
            // Setting wins over clearing so a same-cycle drop is never lost.
            ovfl    <= drop ? 1'b1 : clear ? 1'b0 : ovfl;
        end
    end
endmodule

// File: rtl/router_op_lut_event_pacer.sv
// router_op_lut_event_pacer: re-times per-packet op-LUT events into paced counter update pulses
//   clk    system clock
//   reset  asynchronous active-low reset (asserted when 0)
//   bus    slave side of router_op_lut_event_pacer_if:
//            events_in / clear_ovfl in, updates_out / overflow / busy out
module router_op_lut_event_pacer
    import router_op_lut_event_pacer_pkg::*;
#(
    parameter int NUM_EVENTS          = NUM_COUNTERS,
    parameter int MIN_UPDATE_INTERVAL = DEF_MIN_UPDATE_INTERVAL,
    parameter int ACC_WIDTH           = DEF_ACC_WIDTH
) (
    input logic                          clk,
    input logic                          reset,
    router_op_lut_event_pacer_if.slave   bus
);
    logic [NUM_EVENTS-1:0] update;
    logic [NUM_EVENTS-1:0] ovfl;
    logic [NUM_EVENTS-1:0] pend_nz;
    logic                  busy;

    genvar i;
    generate
        for (i = 0; i < NUM_EVENTS; i++) begin : g_chan
            router_op_lut_event_pacer_chan #(
                .MIN_UPDATE_INTERVAL (MIN_UPDATE_INTERVAL),
                .ACC_WIDTH           (ACC_WIDTH)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .ev      (bus.events_in[i]),
                .clear   (bus.clear_ovfl[i]),
                .update  (update[i]),
                .ovfl    (ovfl[i]),
                .pend_nz (pend_nz[i])
            );
        end
    endgenerate

    // busy reflects the pending counts being loaded this cycle, so it lines up
    // with the registered pending state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= 1'b0;
        else        busy <= |pend_nz;
    end

    assign bus.updates_out = update;
    assign bus.overflow    = ovfl;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_router_op_lut_event_pacer.sv
// tb_router_op_lut_event_pacer: directed self-checking bench for router_op_lut_event_pacer
module tb_router_op_lut_event_pacer;
    localparam int N = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pulses;

    router_op_lut_event_pacer_if #(.NUM_EVENTS(N)) bus ();

    router_op_lut_event_pacer #(
        .NUM_EVENTS          (N),
        .MIN_UPDATE_INTERVAL (8),
        .ACC_WIDTH           (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.events_in  = '0;
        bus.clear_ovfl = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Channel 5 driven for 20 consecutive cycles; emits fall on cycles 0,8,...,136.
    task automatic burst(input logic clr_on_drop);
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            bus.events_in  = (c < 20) ? N'(1 << 5) : '0;
            bus.clear_ovfl = (clr_on_drop && c == 18) ? N'(1 << 5) : '0;
            tick();
            pulses += int'(bus.updates_out[5]);
            chk($sformatf("burst_upd_c%0d", c), 32'(bus.updates_out),
                (c % 8 == 0 && c <= 136) ? 32'(1 << 5) : 32'd0);
            chk($sformatf("burst_busy_c%0d", c), 32'(bus.busy), (c >= 1 && c < 136) ? 32'd1 : 32'd0);
            chk($sformatf("burst_ovf_c%0d", c), 32'(bus.overflow), (c >= 18) ? 32'(1 << 5) : 32'd0);
        end
        chk("burst_pulse_count", 32'(pulses), 32'd18);
    endtask

    initial begin
        bus.events_in  = '0;
        bus.clear_ovfl = '0;
        #2;
        chk("rst_upd", 32'(bus.updates_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        reset = 1'b1;
        idle(2);

        // 1: single pulse on an idle channel goes straight out
        bus.events_in = N'(1 << 3);
        tick();
        bus.events_in = '0;
        chk("s1_upd_c1", 32'(bus.updates_out), 32'(1 << 3));
        chk("s1_busy_c1", 32'(bus.busy), 32'd0);
        tick();
        chk("s1_upd_c2", 32'(bus.updates_out), 32'd0);
        chk("s1_busy_c2", 32'(bus.busy), 32'd0);
        idle(10);

        // 2: three back-to-back events pulse at 1, 9, 17
        for (int c = 0; c < 24; c++) begin
            bus.events_in = (c < 3) ? N'(1 << 2) : '0;
            tick();
            chk($sformatf("s2_upd_c%0d", c + 1), 32'(bus.updates_out),
                (c == 0 || c == 8 || c == 16) ? 32'(1 << 2) : 32'd0);
            chk($sformatf("s2_busy_c%0d", c + 1), 32'(bus.busy),
                (c + 1 >= 2 && c + 1 <= 16) ? 32'd1 : 32'd0);
        end
        idle(4);

        // 3: 20-event burst saturates pending, drops two
        burst(1'b0);
        idle(4);

        // 5a: clear on an idle channel
        bus.clear_ovfl = N'(1 << 5);
        tick();
        bus.clear_ovfl = '0;
        chk("s5_clear_idle", 32'(bus.overflow), 32'd0);

        // 5b: clear in the same cycle as a drop loses to the set
        burst(1'b1);
        idle(4);
        bus.clear_ovfl = N'(1 << 5);
        tick();
        bus.clear_ovfl = '0;
        chk("s5_clear_after", 32'(bus.overflow), 32'd0);
        idle(4);

        // 4: every channel at once, all emitted together
        bus.events_in = '1;
        tick();
        bus.events_in = '0;
        chk("s4_upd_all", 32'(bus.updates_out), 32'h3FF);
        chk("s4_ovf", 32'(bus.overflow), 32'd0);
        chk("s4_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("s4_upd_after", 32'(bus.updates_out), 32'd0);
        idle(10);

        // 6: reset mid-way through scenario 2 discards pending events
        for (int c = 0; c < 4; c++) begin
            bus.events_in = (c < 3) ? N'(1 << 2) : '0;
            tick();
        end
        chk("s6_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("s6_upd_rst", 32'(bus.updates_out), 32'd0);
        chk("s6_busy_rst", 32'(bus.busy), 32'd0);
        chk("s6_ovf_rst", 32'(bus.overflow), 32'd0);
        tick();
        reset = 1'b1;
        idle(3);
        bus.events_in = N'(1 << 2);
        tick();
        bus.events_in = '0;
        chk("s6_upd_new", 32'(bus.updates_out), 32'(1 << 2));
        chk("s6_busy_new", 32'(bus.busy), 32'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("s6_no_leftover_%0d", c), 32'(bus.updates_out), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
